// File: rtl/pcie_avmm_pkg.sv
// Shared widths, FSM encoding and read-tag entry for the two-requester Avalon-MM arbiter.
package pcie_avmm_pkg;

   localparam int unsigned DefAddrW    = 64;
   localparam int unsigned DefDataW    = 512;
   localparam int unsigned DefBurstW   = 4;
   localparam int unsigned DefMaxOutst = 8;
   localparam int unsigned TagCntW     = 8;

   // Arbiter FSM state encoding
   localparam logic StIdle    = 1'b0;
   localparam logic StWrBurst = 1'b1;

   typedef struct packed {
      logic               id;
      logic [TagCntW-1:0] count;
   } tag_entry_t;

   // A zero burstcount behaves as a single-word transfer.
   function automatic logic [TagCntW-1:0] norm_bc(input logic [TagCntW-1:0] bc);
      return (bc == '0) ? TagCntW'(1) : bc;
   endfunction

endpackage

// File: rtl/pcie_avmm_arb_tagq.sv
// In-order queue of outstanding read tags; tracks beats returned against the head entry.
module pcie_avmm_arb_tagq
   import pcie_avmm_pkg::*;
#(
   parameter int unsigned Depth = DefMaxOutst
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  tag_entry_t push_entry_i,
   input  logic       beat_i,
   output logic       head_id_o,
   output logic       empty_o,
   output logic       full_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   tag_entry_t         mem_q [Depth];
   tag_entry_t         head;
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [TagCntW-1:0] beat_q, beat_d;
   logic               push_ok, pop, last_beat;

   assign head      = mem_q[rd_ptr_q];
   assign head_id_o = head.id;
   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == CntW'(Depth));
   assign push_ok   = push_i & ~full_o;
   assign last_beat = (beat_q == head.count - TagCntW'(1));
   assign pop       = beat_i & ~empty_o & last_beat;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      beat_d   = beat_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (pop) begin
         beat_d = '0;
      end else if (beat_i && !empty_o) begin
         beat_d = beat_q + TagCntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         beat_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         beat_q   <= beat_d;
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
   end

endmodule

// File: rtl/pcie_avmm_arb2.sv
// Two-requester round-robin Avalon-MM arbiter with write-burst locking and read-return routing.
module pcie_avmm_arb2
   import pcie_avmm_pkg::*;
#(
   parameter int unsigned ADDR_W    = DefAddrW,
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned BURST_W   = DefBurstW,
   parameter int unsigned MAX_OUTST = DefMaxOutst,
   localparam int unsigned BE_W     = DATA_W / 8
) (
   input  logic               pcie_clk,
   input  logic               pcie_rst_n,
   input  logic [ADDR_W-1:0]  m0_address,
   input  logic               m0_read,
   input  logic               m0_write,
   input  logic [DATA_W-1:0]  m0_writedata,
   input  logic [BE_W-1:0]    m0_byteenable,
   input  logic [BURST_W-1:0] m0_burstcount,
   output logic               m0_waitrequest,
   output logic [DATA_W-1:0]  m0_readdata,
   output logic               m0_readdatavalid,
   input  logic [ADDR_W-1:0]  m1_address,
   input  logic               m1_read,
   input  logic               m1_write,
   input  logic [DATA_W-1:0]  m1_writedata,
   input  logic [BE_W-1:0]    m1_byteenable,
   input  logic [BURST_W-1:0] m1_burstcount,
   output logic               m1_waitrequest,
   output logic [DATA_W-1:0]  m1_readdata,
   output logic               m1_readdatavalid,
   output logic [ADDR_W-1:0]  s_address,
   output logic               s_read,
   output logic               s_write,
   output logic [DATA_W-1:0]  s_writedata,
   output logic [BE_W-1:0]    s_byteenable,
   output logic [BURST_W-1:0] s_burstcount,
   input  logic               s_waitrequest,
   input  logic [DATA_W-1:0]  s_readdata,
   input  logic               s_readdatavalid
);

   logic               state_q, state_d;
   logic               last_q, last_d;
   logic               lock_q, lock_d;
   logic [TagCntW-1:0] beats_q, beats_d;

   logic               full, empty, head_id;
   logic               req0, req1, gnt_vld, gnt_id;
   logic               sel_read, sel_write, accept, push, rvalid;
   logic [BURST_W-1:0] sel_bc;
   logic [TagCntW-1:0] bc_norm;
   tag_entry_t         push_entry;

   // Reads are ineligible while the tag queue is full; writes never are.
   assign req0 = m0_write | (m0_read & ~full);
   assign req1 = m1_write | (m1_read & ~full);

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (state_q == StIdle) begin
         gnt_vld = req0 | req1;
         gnt_id  = (req0 & req1) ? ~last_q : req1;
      end else begin
         gnt_id  = lock_q;
         gnt_vld = lock_q ? m1_write : m0_write;
      end
      gnt_vld = gnt_vld & pcie_rst_n;
   end

   assign sel_read  = gnt_id ? m1_read : m0_read;
   assign sel_write = gnt_id ? m1_write : m0_write;
   assign sel_bc    = gnt_id ? m1_burstcount : m0_burstcount;
   assign bc_norm   = norm_bc(TagCntW'(sel_bc));

   assign s_read       = gnt_vld & sel_read & (state_q == StIdle);
   assign s_write      = gnt_vld & sel_write;
   assign s_address    = gnt_id ? m1_address : m0_address;
   assign s_writedata  = gnt_id ? m1_writedata : m0_writedata;
   assign s_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
   assign s_burstcount = sel_bc;

   assign m0_waitrequest = ~(gnt_vld & ~gnt_id) | s_waitrequest;
   assign m1_waitrequest = ~(gnt_vld & gnt_id) | s_waitrequest;

   assign accept           = gnt_vld & ~s_waitrequest;
   assign push             = accept & s_read;
   assign push_entry.id    = gnt_id;
   assign push_entry.count = bc_norm;

   assign rvalid           = s_readdatavalid & ~empty & pcie_rst_n;
   assign m0_readdatavalid = rvalid & ~head_id;
   assign m1_readdatavalid = rvalid & head_id;
   assign m0_readdata      = m0_readdatavalid ? s_readdata : '0;
   assign m1_readdata      = m1_readdatavalid ? s_readdata : '0;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      lock_d  = lock_q;
      beats_d = beats_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               last_d = gnt_id;
               if (s_write && bc_norm > TagCntW'(1)) begin
                  state_d = StWrBurst;
                  lock_d  = gnt_id;
                  beats_d = bc_norm - TagCntW'(1);
               end
            end
         end
         StWrBurst: begin
            if (accept) begin
               beats_d = beats_q - TagCntW'(1);
               if (beats_q == TagCntW'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // last_q resets to m1 so that m0 wins the first contested cycle.
   always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         lock_q  <= 1'b0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         lock_q  <= lock_d;
         beats_q <= beats_d;
      end
   end

   pcie_avmm_arb_tagq #(
      .Depth (MAX_OUTST)
   ) u_tagq (
      .clk_i        (pcie_clk),
      .rst_ni       (pcie_rst_n),
      .push_i       (push),
      .push_entry_i (push_entry),
      .beat_i       (rvalid),
      .head_id_o    (head_id),
      .empty_o      (empty),
      .full_o       (full)
   );

endmodule

// File: tb/tb_pcie_avmm_arb2.sv
// Directed bench for pcie_avmm_arb2: table-driven arbitration vectors plus multi-cycle sequences.
module tb_pcie_avmm_arb2;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 512;
   localparam int unsigned BE_W   = 64;
   localparam int unsigned BW     = 4;
   localparam logic [63:0] A0     = 64'h1000;
   localparam logic [63:0] A1     = 64'h2000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] m0_address, m1_address, s_address;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
   logic [BW-1:0]     m0_burstcount, m1_burstcount, s_burstcount;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic              s_read, s_write, s_waitrequest, s_readdatavalid;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pcie_avmm_arb2 dut (
      .pcie_clk         (clk),
      .pcie_rst_n       (rst_n),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_burstcount    (m0_burstcount),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_burstcount    (m1_burstcount),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_burstcount     (s_burstcount),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid)
   );

   typedef struct {
      logic m0r, m0w, m1r, m1w, sw;
      logic er, ew, eg, ew0, ew1;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      m0_burstcount = 1; m1_burstcount = 1;
      m0_writedata = '0; m1_writedata = '0;
      s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " s_read"}, s_read, 0);
      chk({tag, " s_write"}, s_write, 0);
      chk({tag, " m0_wait"}, m0_waitrequest, 1);
      chk({tag, " m1_wait"}, m1_waitrequest, 1);
      chk({tag, " m0_rdv"}, m0_readdatavalid, 0);
      chk({tag, " m1_rdv"}, m1_readdatavalid, 0);
   endtask

   // Holds reset across one rising edge with requesters active, then releases it.
   task automatic reset_dut();
      step();
      rst_n = 0;
      m0_write = 1; m1_write = 1; s_readdatavalid = 1;
      #1;
      chk_reset_outs("rst");
      step();
      rst_n = 1;
      idle_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      m0_address = A0; m1_address = A1;
      m0_byteenable = '1; m1_byteenable = '1;
      idle_inputs();
      rst_n = 0;
      m0_write = 1;
      #2;
      chk_reset_outs("por");
      reset_dut();

      //              m0r m0w m1r m1w sw  er ew eg w0 w1
      vecs[0] = '{0, 1, 0, 1, 0,  0, 1, 0, 0, 1};
      vecs[1] = '{0, 1, 0, 1, 0,  0, 1, 1, 1, 0};
      vecs[2] = '{0, 1, 0, 1, 0,  0, 1, 0, 0, 1};
      vecs[3] = '{0, 1, 0, 1, 1,  0, 1, 1, 1, 1};
      vecs[4] = '{0, 1, 0, 1, 0,  0, 1, 1, 1, 0};
      vecs[5] = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 1};
      vecs[6] = '{0, 0, 1, 0, 1,  1, 0, 1, 1, 1};
      vecs[7] = '{1, 0, 0, 1, 1,  1, 0, 0, 1, 1};
      vecs[8] = '{0, 0, 0, 1, 0,  0, 1, 1, 1, 0};
      vecs[9] = '{0, 1, 0, 0, 0,  0, 1, 0, 0, 1};

      for (int i = 0; i < 10; i++) begin
         m0_read = vecs[i].m0r; m0_write = vecs[i].m0w;
         m1_read = vecs[i].m1r; m1_write = vecs[i].m1w;
         s_waitrequest = vecs[i].sw;
         #1;
         chk($sformatf("vec%0d s_read", i), s_read, vecs[i].er);
         chk($sformatf("vec%0d s_write", i), s_write, vecs[i].ew);
         chk($sformatf("vec%0d m0_wait", i), m0_waitrequest, vecs[i].ew0);
         chk($sformatf("vec%0d m1_wait", i), m1_waitrequest, vecs[i].ew1);
         if (vecs[i].er || vecs[i].ew)
            chk($sformatf("vec%0d s_addr", i), s_address[63:0], vecs[i].eg ? A1 : A0);
         step();
      end

      // Write burst of 4 from m0 with m1 queued behind it and one stall on beat 3.
      reset_dut();
      m0_write = 1; m0_burstcount = 4; m0_writedata = 512'hA0;
      #1;
      chk("bst0 s_write", s_write, 1);
      chk("bst0 s_bc", s_burstcount, 4);
      chk("bst0 s_wd", s_writedata[63:0], 64'hA0);
      chk("bst0 m0_wait", m0_waitrequest, 0);
      step();
      m0_writedata = 512'hA1; m0_burstcount = 7; m1_write = 1;
      #1;
      chk("bst1 s_addr", s_address[63:0], A0);
      chk("bst1 s_wd", s_writedata[63:0], 64'hA1);
      chk("bst1 m0_wait", m0_waitrequest, 0);
      chk("bst1 m1_wait", m1_waitrequest, 1);
      step();
      m0_writedata = 512'hA2; s_waitrequest = 1;
      #1;
      chk("bst2stall s_write", s_write, 1);
      chk("bst2stall m0_wait", m0_waitrequest, 1);
      chk("bst2stall m1_wait", m1_waitrequest, 1);
      step();
      s_waitrequest = 0;
      #1;
      chk("bst2 s_wd", s_writedata[63:0], 64'hA2);
      chk("bst2 m0_wait", m0_waitrequest, 0);
      chk("bst2 m1_wait", m1_waitrequest, 1);
      step();
      m0_writedata = 512'hA3;
      #1;
      chk("bst3 s_addr", s_address[63:0], A0);
      chk("bst3 s_wd", s_writedata[63:0], 64'hA3);
      chk("bst3 m1_wait", m1_waitrequest, 1);
      step();
      m0_write = 0;
      #1;
      chk("bstm1 s_write", s_write, 1);
      chk("bstm1 s_addr", s_address[63:0], A1);
      chk("bstm1 m1_wait", m1_waitrequest, 0);
      step();
      // burstcount 0 must behave as a single word, leaving no lock on m0.
      m0_write = 1; m0_burstcount = 0;
      #1;
      chk("bc0 m0_wait", m0_waitrequest, 0);
      step();
      #1;
      chk("bc0 next s_addr", s_address[63:0], A1);
      chk("bc0 next m1_wait", m1_waitrequest, 0);
      step();

      // Reads from both requesters; returns routed in issue order, with a push during a pop.
      reset_dut();
      m0_read = 1; m0_burstcount = 2;
      #1;
      chk("rd0 s_read", s_read, 1);
      chk("rd0 s_bc", s_burstcount, 2);
      chk("rd0 m0_wait", m0_waitrequest, 0);
      step();
      m0_read = 0; m1_read = 1; m1_burstcount = 3;
      #1;
      chk("rd1 s_addr", s_address[63:0], A1);
      chk("rd1 m1_wait", m1_waitrequest, 0);
      step();
      m1_read = 0; s_readdatavalid = 1; s_readdata = 512'h100;
      #1;
      chk("ret0 m0_rdv", m0_readdatavalid, 1);
      chk("ret0 m1_rdv", m1_readdatavalid, 0);
      chk("ret0 m0_rd", m0_readdata[63:0], 64'h100);
      step();
      s_readdata = 512'h101; m1_read = 1; m1_burstcount = 1;
      #1;
      chk("ret1 m0_rdv", m0_readdatavalid, 1);
      chk("ret1 m1_rdv", m1_readdatavalid, 0);
      chk("ret1 push m1_wait", m1_waitrequest, 0);
      step();
      m1_read = 0;
      for (int b = 2; b < 6; b++) begin
         s_readdata = 512'(256 + b);
         #1;
         chk($sformatf("ret%0d m1_rdv", b), m1_readdatavalid, 1);
         chk($sformatf("ret%0d m0_rdv", b), m0_readdatavalid, 0);
         chk($sformatf("ret%0d m1_rd", b), m1_readdata[63:0], 64'(256 + b));
         step();
      end
      s_readdata = 512'h1FF;
      #1;
      chk("retx m0_rdv", m0_readdatavalid, 0);
      chk("retx m1_rdv", m1_readdatavalid, 0);
      step();
      s_readdatavalid = 0;

      // Fill the tag queue; the ninth read stalls while a write still gets through.
      reset_dut();
      m0_read = 1;
      for (int n = 0; n < 8; n++) begin
         #1;
         chk($sformatf("fill%0d m0_wait", n), m0_waitrequest, 0);
         step();
      end
      m1_write = 1;
      #1;
      chk("full m0_wait", m0_waitrequest, 1);
      chk("full m1_wait", m1_waitrequest, 0);
      chk("full s_write", s_write, 1);
      chk("full s_read", s_read, 0);
      step();
      m1_write = 0;
      #1;
      chk("full2 m0_wait", m0_waitrequest, 1);
      chk("full2 s_read", s_read, 0);
      step();
      s_readdatavalid = 1;
      #1;
      chk("fullpop m0_rdv", m0_readdatavalid, 1);
      chk("fullpop m0_wait", m0_waitrequest, 1);
      step();
      s_readdatavalid = 0;
      #1;
      chk("afterpop m0_wait", m0_waitrequest, 0);
      chk("afterpop s_read", s_read, 1);
      step();
      m0_read = 0;

      // Reset in the middle of a burst with a read outstanding.
      reset_dut();
      m1_read = 1;
      #1;
      chk("mid rd m1_wait", m1_waitrequest, 0);
      step();
      m1_read = 0; m0_write = 1; m0_burstcount = 4;
      step();
      #1;
      chk("mid beat2 s_write", s_write, 1);
      rst_n = 0;
      s_readdatavalid = 1;
      #1;
      chk_reset_outs("midrst");
      step();
      rst_n = 1;
      m0_write = 0;
      #1;
      chk("late m1_rdv", m1_readdatavalid, 0);
      chk("late m0_rdv", m0_readdatavalid, 0);
      s_readdatavalid = 0;
      m0_write = 1; m1_write = 1; m0_burstcount = 1; m1_burstcount = 1;
      #1;
      chk("post s_addr", s_address[63:0], A0);
      chk("post m0_wait", m0_waitrequest, 0);
      chk("post m1_wait", m1_waitrequest, 1);
      step();
      #1;
      chk("post2 m1_wait", m1_waitrequest, 0);
      step();
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pcie_avmm_arb2.md
PCIE_AVMM_ARB2 -- requirements
Module: pcie_avmm_arb2

Interface
REQ-001 Parameter ADDR_W, default 64, Avalon address width.
REQ-002 Parameter DATA_W, default 512, data width; BE_W = DATA_W/8 (64).
REQ-003 Parameter BURST_W, default 4, burstcount width (1..8 words legal).
REQ-004 Parameter MAX_OUTST, default 8, maximum outstanding read commands (power of 2).
REQ-005 pcie_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 pcie_rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided upstream.
REQ-007 m0_/m1_address  in  ADDR_W each  requester command address.
REQ-008 m0_/m1_read, m0_/m1_write  in  1 each  requester commands; read and write are never asserted together.
REQ-009 m0_/m1_writedata, m0_/m1_byteenable  in  DATA_W, BE_W each  write payload.
REQ-010 m0_/m1_burstcount  in  BURST_W each  burst length in words.
REQ-011 m0_/m1_waitrequest  out  1 each  stall to requester.
REQ-012 m0_/m1_readdata, m0_/m1_readdatavalid  out  DATA_W, 1 each  routed read return.
REQ-013 s_address, s_read, s_write, s_writedata, s_byteenable, s_burstcount  out  ADDR_W,1,1,DATA_W,BE_W,BURST_W  shared downstream command port.
REQ-014 s_waitrequest, s_readdata, s_readdatavalid  in  1, DATA_W, 1  downstream response.

Function
REQ-015 States IDLE and WR_BURST; IDLE selects a winner each cycle among requesters asserting read or write.
REQ-016 Round-robin: the last-granted requester has lowest priority; after reset m0 has priority.
REQ-017 Winner's command drives s_* combinationally the same cycle; winner's waitrequest = s_waitrequest; loser's waitrequest = 1.
REQ-018 No requester active: s_read = s_write = 0, both waitrequests = 1.
REQ-019 Write accepted (s_write & !s_waitrequest) with burstcount > 1: enter WR_BURST locked to that requester with beat counter = burstcount-1.
REQ-020 WR_BURST: only locked requester forwarded; counter decrements per accepted beat; return to IDLE after final beat; burstcount on non-first beats ignored.
REQ-021 Read accepted: push {requester id, burstcount} into tag queue; read is a single command cycle.
REQ-022 Tag queue holding MAX_OUTST entries: read requesters not eligible (waitrequest = 1); writes still arbitrated.
REQ-023 s_readdatavalid: s_readdata and valid routed to queue-head requester only; head beat counter decrements; entry popped on last beat.
REQ-024 Push and pop in same cycle when not full are both performed; occupancy unchanged.
REQ-025 burstcount = 0 is treated as 1.
REQ-026 s_readdatavalid with empty queue is dropped, raises no output.
REQ-027 Arbitration latency zero cycles: uncontended request with s_waitrequest = 0 is accepted the cycle it is presented.

Reset
REQ-028 pcie_rst_n low: state = IDLE, priority = m0, tag queue empty, counters 0; s_read = s_write = 0, m0/m1_waitrequest = 1, m0/m1_readdatavalid = 0.
REQ-029 Reset mid-burst or with reads outstanding discards all state; late read data after reset is dropped per REQ-026.

Structure
REQ-030 Package pcie_avmm_pkg holds default widths, MAX_OUTST, state enum, and tag-entry struct {id, count}.
REQ-031 Sub-module pcie_avmm_arb_tagq: MAX_OUTST-deep FIFO with full/empty and head beat counter.

Verification
REQ-032 m0 and m1 both issue single writes continuously, s_waitrequest = 0 -> grants alternate m0,m1,m0,m1 starting with m0.
REQ-033 m0 write burstcount 4, m1 write requested on beat 2 -> s_* carries 4 m0 beats contiguously, m1 accepted cycle after m0's last beat.
REQ-034 m0 read bc 2, then m1 read bc 3; downstream returns 5 beats -> first 2 to m0_readdatavalid, next 3 to m1 only.
REQ-035 9 reads issued without returns (MAX_OUTST = 8) -> 9th held with waitrequest = 1 until first entry pops; concurrent m1 write still accepted.
REQ-036 Assert pcie_rst_n low on beat 2 of a bc 4 write -> outputs reach REQ-028 values immediately; post-reset requests arbitrate from m0.
